// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB bus arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int SEL_LSB = 12;
    localparam int SEL_W   = 4;
    localparam int APB_AW  = 32;
    localparam int APB_DW  = 32;

    // Slave number encoded in the address select field.
    function automatic logic [SEL_W-1:0] slave_index(input logic [APB_AW-1:0] addr);
        return addr[SEL_LSB +: SEL_W];
    endfunction

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the slave fabric.
interface apb_bus_arbiter_if #(
    parameter int NSLV = 4
);
    import apb_arb_pkg::*;

    logic [APB_AW-1:0] paddr;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin requester selection. Purely combinational: the search starts
// at ptr and wraps; the pointer register itself lives in the caller.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master port between NREQ requesters and sequences
// SETUP/ACCESS. Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | bus idle; arbitrate, latch winner, or answer a decode miss
//  ST_SETUP  | psel asserted, penable low, one cycle
//  ST_ACCESS | penable high, waiting for pready; may chain to next SETUP
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*APB_AW-1:0] req_addr,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*APB_DW-1:0] req_wdata,
    output logic [NREQ-1:0]        done,
    output logic [APB_DW-1:0]      rsp_rdata,
    output logic                   rsp_err,
    apb_bus_arbiter_if.master      bus
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || NSLV < 1 || NSLV > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_bus_arbiter: parameter out of range");
    end

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  cur;
    logic [NREQ-1:0]   cur_oh;
    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   win_grant;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic [APB_AW-1:0] win_addr;
    logic [APB_DW-1:0] win_wdata;
    logic              win_write;
    logic              win_hit;
    logic [NSLV-1:0]   win_sel_oh;
    logic [IDX_W-1:0]  next_ptr;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_cnt;
`endif

    // Requests eligible for arbitration: the requester being answered this
    // cycle (done high) or completing now still holds req, so mask it out.
    always_comb begin
        cur_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            cur_oh[k] = (int'(cur) == k);
        end
        req_eff = req & ~done & ((state == ST_ACCESS) ? ~cur_oh : {NREQ{1'b1}});
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_eff),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Winner payload, slave decode and the pointer value after a grant.
    always_comb begin
        logic [SEL_W-1:0] sel;
        win_addr  = req_addr[int'(win_idx)*APB_AW +: APB_AW];
        win_wdata = req_wdata[int'(win_idx)*APB_DW +: APB_DW];
        win_write = req_write[win_idx];
        sel       = slave_index(win_addr);
        win_hit   = (int'(sel) < NSLV);
        win_sel_oh = '0;
        for (int k = 0; k < NSLV; k++) begin
            win_sel_oh[k] = (int'(sel) == k);
        end
        next_ptr = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end

    // Protocol FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cur         <= '0;
            done        <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            bus.paddr   <= '0;
            bus.psel    <= '0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.pwdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        ptr <= next_ptr;
                        cur <= win_idx;
                        if (win_hit) begin
                            bus.paddr  <= win_addr;
                            bus.pwrite <= win_write;
                            bus.pwdata <= win_wdata;
                            bus.psel   <= win_sel_oh;
                            state      <= ST_SETUP;
                        end else begin
                            // Decode miss is answered without touching the bus.
                            done      <= win_grant;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt     <= TMO_W'(TIMEOUT - 1);
`endif
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        done        <= cur_oh;
                        rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                        rsp_err     <= bus.pslverr;
                        bus.penable <= 1'b0;
                        // Chain straight into SETUP only for a decodable
                        // winner; a miss is answered from IDLE next cycle.
                        if (win_valid && win_hit) begin
                            ptr        <= next_ptr;
                            cur        <= win_idx;
                            bus.paddr  <= win_addr;
                            bus.pwrite <= win_write;
                            bus.pwdata <= win_wdata;
                            bus.psel   <= win_sel_oh;
                            state      <= ST_SETUP;
                        end else begin
                            bus.psel <= '0;
                            state    <= ST_IDLE;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        done        <= cur_oh;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        bus.psel    <= '0;
                        bus.penable <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: a vector table of single transfers
// plus hand-written sequences for reset mid-ACCESS, contention and
// round-robin order. Outputs are sampled on the falling clock edge.
module tb_apb_bus_arbiter;
    import apb_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int NSLV = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*APB_AW-1:0] req_addr;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*APB_DW-1:0] req_wdata;
    logic [NREQ-1:0]        done;
    logic [APB_DW-1:0]      rsp_rdata;
    logic                   rsp_err;

    apb_bus_arbiter_if #(.NSLV(NSLV)) bus ();

    apb_bus_arbiter #(
        .NREQ    (NREQ),
        .NSLV    (NSLV),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [3:0]  exp_psel;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    // One isolated transfer; latency counted in falling edges from req rise.
    task automatic run_txn(input vec_t v);
        int          n, acc, lat;
        logic        got, stable;
        logic [3:0]  any_psel, s_psel, done_v;
        logic [31:0] s_addr, s_wdata, rd;
        logic        s_write, er;
        n = 0; acc = 0; lat = 0; got = 1'b0; stable = 1'b1;
        any_psel = '0; s_psel = '0; done_v = '0;
        s_addr = '0; s_wdata = '0; s_write = 1'b0; rd = '0; er = 1'b0;
        req_addr[32*v.idx +: 32]  = v.addr;
        req_wdata[32*v.idx +: 32] = v.wdata;
        req_write[v.idx]          = v.write;
        req[v.idx]                = 1'b1;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            any_psel = any_psel | bus.psel;
            if (bus.psel != '0 && !bus.penable) begin
                s_psel = bus.psel; s_addr = bus.paddr;
                s_write = bus.pwrite; s_wdata = bus.pwdata;
            end
            if (bus.penable) begin
                acc++;
                if (bus.psel !== s_psel || bus.paddr !== s_addr ||
                    bus.pwrite !== s_write || bus.pwdata !== s_wdata) stable = 1'b0;
            end
            if (done != '0) begin
                got = 1'b1; lat = n; done_v = done; rd = rsp_rdata; er = rsp_err;
            end
            bus.pready  = (acc > v.waits);
            bus.prdata  = bus.pready ? v.prdata : 32'h0;
            bus.pslverr = bus.pready ? v.slverr : 1'b0;
        end
        req[v.idx] = 1'b0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", lat, v.exp_lat);
        check("done_vec", 32'(done_v), 32'(4'b0001 << v.idx));
        check("rsp_rdata", rd, v.exp_rdata);
        check("rsp_err", 32'(er), 32'(v.exp_err));
        check("psel_seen", 32'(any_psel), 32'(v.exp_psel));
        if (v.exp_psel != '0) begin
            check("paddr", s_addr, v.addr);
            check("pwrite", 32'(s_write), 32'(v.write));
            if (v.write) check("pwdata", s_wdata, v.wdata);
            check("bus_stable", 32'(stable), 32'd1);
            check("access_cycles", acc, v.waits + 1);
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("psel_dropped", 32'(bus.psel), 32'd0);
        @(negedge clk);
    endtask

    int done_ord[8], done_at[8], setup_ps[8], setup_at[8];
    int n_done, n_setup;

    // Several simultaneous writes, each requester i targeting slave i.
    task automatic run_multi(input logic [3:0] mask);
        int n;
        n = 0; n_done = 0; n_setup = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[32*i +: 32]  = (32'(i) << 12) | 32'h10;
            req_wdata[32*i +: 32] = 32'h5000_0000 + 32'(i);
            req_write[i]          = 1'b1;
        end
        bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = '0;
        req = mask;
        while (n_done < $countones(mask) && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.psel != '0 && !bus.penable && n_setup < 8) begin
                setup_ps[n_setup] = int'(bus.psel); setup_at[n_setup] = n; n_setup++;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (done[k] && n_done < 8) begin
                    done_ord[n_done] = k; done_at[n_done] = n; n_done++;
                    req[k] = 1'b0;
                end
            end
        end
        req = '0; bus.pready = 1'b0;
        check("multi_done_count", n_done, $countones(mask));
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] or_done;
        logic [3:0] or_psel;
        logic       reached;
        vec_t       v;

        rst = 1'b1; req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_psel", 32'(bus.psel), 32'd0);
        check("rst_penable", 32'(bus.penable), 32'd0);
        check("rst_pwrite", 32'(bus.pwrite), 32'd0);
        check("rst_paddr", bus.paddr, 32'd0);
        check("rst_pwdata", bus.pwdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //          idx wr addr           wdata          waits prdata         err  psel     lat rdata          err
        vecs[0] = '{0, 1'b1, 32'h0000_1004, 32'hA5A5_0001, 0, 32'h0000_0000, 1'b0, 4'b0010, 3, 32'h0000_0000, 1'b0};
        vecs[1] = '{2, 1'b0, 32'h0000_0008, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 4'b0001, 6, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1, 1'b1, 32'h0000_7000, 32'h1111_2222, 0, 32'h0000_0000, 1'b0, 4'b0000, 1, 32'h0000_0000, 1'b1};
        vecs[3] = '{3, 1'b0, 32'h0000_3010, 32'h0000_0000, 0, 32'h1234_5678, 1'b1, 4'b1000, 3, 32'h1234_5678, 1'b1};
        vecs[4] = '{3, 1'b0, 32'h0000_2000, 32'h0000_0000, 1, 32'hCAFE_0000, 1'b0, 4'b0100, 4, 32'hCAFE_0000, 1'b0};
        vecs[5] = '{1, 1'b1, 32'h0000_2ABC, 32'h0BAD_F00D, 2, 32'hFFFF_FFFF, 1'b0, 4'b0100, 5, 32'h0000_0000, 1'b0};
        vecs[6] = '{0, 1'b0, 32'h0000_4000, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 4'b0000, 1, 32'h0000_0000, 1'b1};
        vecs[7] = '{2, 1'b0, 32'h0000_3FFC, 32'h0000_0000, 0, 32'h0000_0001, 1'b0, 4'b1000, 3, 32'h0000_0001, 1'b0};

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Reset while in ACCESS: bus idles, no done, requester gives up.
        req_addr[31:0] = 32'h0000_1000; req_write[0] = 1'b0; req[0] = 1'b1;
        bus.pready = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 10 && !reached; n++) begin
            @(negedge clk);
            reached = bus.penable;
        end
        check("mid_access_reached", 32'(reached), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_psel", 32'(bus.psel), 32'd0);
        check("mid_rst_penable", 32'(bus.penable), 32'd0);
        check("mid_rst_paddr", bus.paddr, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0; req = '0;
        or_done = '0; or_psel = '0;
        repeat (4) begin
            @(negedge clk);
            or_done = or_done | done;
            or_psel = or_psel | bus.psel;
        end
        check("post_rst_no_done", 32'(or_done), 32'd0);
        check("post_rst_no_psel", 32'(or_psel), 32'd0);

        // All four at once after reset: 0,1,2,3 with SETUP every other cycle.
        run_multi(4'b1111);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_order%0d", k), done_ord[k], k);
            check($sformatf("cont_done_at%0d", k), done_at[k], 2*k + 3);
            check($sformatf("cont_setup_at%0d", k), setup_at[k], 2*k + 1);
            check($sformatf("cont_setup_psel%0d", k), setup_ps[k], 1 << k);
        end

        // Pointer moves past requester 2, so 3 beats 0 on the next tie.
        v = '{2, 1'b0, 32'h0000_2000, 32'h0, 0, 32'h0000_00AA, 1'b0, 4'b0100, 3, 32'h0000_00AA, 1'b0};
        run_txn(v);
        run_multi(4'b1001);
        check("rr_first", done_ord[0], 3);
        check("rr_second", done_ord[1], 0);
        check("rr_first_at", done_at[0], 3);
        check("rr_second_at", done_at[1], 5);

`ifdef APB_ARB_TIMEOUT_EN
        v = '{1, 1'b0, 32'h0000_0000, 32'h0, 1000, 32'h0, 1'b0, 4'b0001, 18, 32'h0, 1'b1};
        run_txn(v);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
